// File: rtl/vliw_loader.sv
// rtl/vliw_loader.sv - boot-time UART-to-imem VLIW bundle loader
//
// Receives a framed byte stream: START_BYTE, LEN (2 bytes, little-endian),
// LEN*16 payload bytes and an XOR checksum byte. Every 16 payload bytes
// form one 128-bit bundle, written to consecutive imem addresses from 0.
// An ack byte (ACK_OK / ACK_NG) is returned once the checksum is compared.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   rx_data, rx_valid          byte strobe from the UART receiver (no backpressure)
//   tx_data, tx_valid, tx_ready  ack byte handshake to the UART transmitter
//   imem_we, imem_addr, imem_wdata  one-cycle bundle write into imem
//   loading                    high while a frame is in progress (core stall)
//   load_done                  high after the ack has been accepted
module vliw_loader #(
  parameter int          ADDR_W     = 14,
  parameter logic [7:0]  START_BYTE = 8'h99,
  parameter logic [7:0]  ACK_OK     = 8'hAA,
  parameter logic [7:0]  ACK_NG     = 8'h55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [127:0]      imem_wdata,
  output logic              loading,
  output logic              load_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_ACK,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0]       len_q;
  logic [15:0]       bundle_cnt;
  logic [3:0]        byte_cnt;
  logic [7:0]        acc;
  logic [127:0]      shift_q;
  logic [ADDR_W-1:0] next_addr;

  logic start_frame;
  logic data_byte;
  logic bundle_full;
  logic last_bundle;

  assign start_frame = rx_valid && (rx_data == START_BYTE) &&
                       ((state == S_IDLE) || (state == S_DONE));
  assign data_byte   = rx_valid && (state == S_DATA);
  assign bundle_full = data_byte && (byte_cnt == 4'hF);
  assign last_bundle = bundle_full && ((bundle_cnt + 16'd1) == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    loading   = 1'b0;
    tx_valid  = 1'b0;
    load_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_frame) state_nxt = S_LEN0;
      end
      S_LEN0: begin
        loading = 1'b1;
        if (rx_valid) state_nxt = S_LEN1;
      end
      S_LEN1: begin
        loading = 1'b1;
        if (rx_valid) begin
          state_nxt = ({rx_data, len_q[7:0]} != 16'd0) ? S_DATA : S_CSUM;
        end
      end
      S_DATA: begin
        loading = 1'b1;
        if (last_bundle) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        loading = 1'b1;
        if (rx_valid) state_nxt = S_ACK;
      end
      S_ACK: begin
        loading  = 1'b1;
        tx_valid = 1'b1;
        if (tx_ready) state_nxt = S_DONE;
      end
      S_DONE: begin
        load_done = 1'b1;
        if (start_frame) state_nxt = S_LEN0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      bundle_cnt <= '0;
      byte_cnt   <= '0;
      acc        <= '0;
      shift_q    <= '0;
      next_addr  <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      tx_data    <= '0;
    end else begin
      imem_we <= bundle_full;
      if (start_frame) begin
        bundle_cnt <= '0;
        byte_cnt   <= '0;
        acc        <= '0;
        shift_q    <= '0;
        next_addr  <= '0;
      end
      if (rx_valid && (state == S_LEN0)) len_q[7:0]  <= rx_data;
      if (rx_valid && (state == S_LEN1)) len_q[15:8] <= rx_data;
      if (data_byte) begin
        shift_q  <= {rx_data, shift_q[127:8]};
        acc      <= acc ^ rx_data;
        byte_cnt <= byte_cnt + 4'd1;
      end
      // The completed bundle is copied out of the shift register so the
      // first byte of the next bundle can shift in during the write cycle.
      if (bundle_full) begin
        imem_wdata <= {rx_data, shift_q[127:8]};
        imem_addr  <= next_addr;
        next_addr  <= next_addr + 1'b1;
        bundle_cnt <= bundle_cnt + 16'd1;
      end
      if (rx_valid && (state == S_CSUM)) begin
        tx_data <= (rx_data == acc) ? ACK_OK : ACK_NG;
      end
    end
  end

endmodule

// File: tb/tb_vliw_loader.sv
// tb/tb_vliw_loader.sv - directed self-checking bench for vliw_loader
module tb_vliw_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          tx_ready = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [127:0]  imem_wdata;
  logic          loading;
  logic          load_done;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int base = 0;
  logic [AW-1:0] wr_addr[$];
  logic [127:0]  wr_data[$];

  always #5 clk = ~clk;

  vliw_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .loading(loading), .load_done(load_done)
  );

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic handshake();
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_txv"}, tx_valid, 0);
    chk({tag, "_txd"}, tx_data, 0);
    chk({tag, "_loading"}, loading, 0);
    chk({tag, "_done"}, load_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_loading", loading, 0);

    // two-bundle frame, good checksum
    base = wr_cnt;
    send(8'h99);
    chk("t1_loading_rise", loading, 1);
    send(8'h02);
    send(8'h00);
    for (int j = 0; j < 16; j++) send(8'(j));
    chk("t1_we0", imem_we, 1);
    chk("t1_addr0", imem_addr, 0);
    chk("t1_wdata0", imem_wdata, 128'h0F0E0D0C0B0A09080706050403020100);
    for (int j = 16; j < 32; j++) send(8'(j));
    chk("t1_we1", imem_we, 1);
    chk("t1_addr1", imem_addr, 1);
    chk("t1_wdata1", imem_wdata, 128'h1F1E1D1C1B1A19181716151413121110);
    send(8'h00);
    chk("t1_we_after", imem_we, 0);
    chk("t1_txv", tx_valid, 1);
    chk("t1_txd", tx_data, 8'hAA);
    chk("t1_wrcnt", wr_cnt - base, 2);
    handshake();
    chk("t1_txv_fall", tx_valid, 0);
    chk("t1_loading_fall", loading, 0);
    chk("t1_done", load_done, 1);

    // same frame, bad checksum (reload from DONE)
    base = wr_cnt;
    send(8'h99);
    chk("t2_done_clr", load_done, 0);
    chk("t2_loading", loading, 1);
    send(8'h02);
    send(8'h00);
    for (int j = 0; j < 32; j++) send(8'(j));
    send(8'h01);
    chk("t2_txv", tx_valid, 1);
    chk("t2_txd", tx_data, 8'h55);
    chk("t2_wrcnt", wr_cnt - base, 2);
    chk("t2_addr0", wr_addr[base], 0);
    chk("t2_addr1", wr_addr[base+1], 1);
    chk("t2_wdata0", wr_data[base], 128'h0F0E0D0C0B0A09080706050403020100);
    chk("t2_wdata1", wr_data[base+1], 128'h1F1E1D1C1B1A19181716151413121110);
    handshake();
    chk("t2_done", load_done, 1);

    // noise in DONE, then LEN=0 frame
    base = wr_cnt;
    send(8'h00);
    send(8'h55);
    send(8'hAA);
    chk("t3_noise_done", load_done, 1);
    chk("t3_noise_loading", loading, 0);
    send(8'h99);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    chk("t3_txv", tx_valid, 1);
    chk("t3_txd", tx_data, 8'hAA);
    chk("t3_nowrites", wr_cnt - base, 0);

    // hold tx_ready low for 10 cycles; a start byte arriving in ACK is dropped
    for (int i = 0; i < 10; i++) begin
      if (i == 3) send(8'h99);
      else @(negedge clk);
      chk("t3_hold_txv", tx_valid, 1);
      chk("t3_hold_txd", tx_data, 8'hAA);
    end
    handshake();
    chk("t3_hs_txv", tx_valid, 0);
    chk("t3_hs_done", load_done, 1);
    @(negedge clk);
    chk("t3_single_hs", tx_valid, 0);

    // reload from DONE restarts at address 0
    base = wr_cnt;
    send(8'h99);
    send(8'h01);
    send(8'h00);
    for (int j = 0; j < 16; j++) send(8'(8'h30 + j));
    chk("t3r_we", imem_we, 1);
    chk("t3r_addr", imem_addr, 0);
    chk("t3r_wdata", imem_wdata, 128'h3F3E3D3C3B3A39383736353433323130);
    send(8'h00);
    chk("t3r_txd", tx_data, 8'hAA);
    handshake();

    // reset mid-bundle
    send(8'h99);
    send(8'h01);
    send(8'h00);
    for (int j = 0; j < 8; j++) send(8'(8'h10 + j));
    base = wr_cnt;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_nowrite", wr_cnt - base, 0);
    send(8'h55);
    chk("t4_idle_noise", loading, 0);
    send(8'h99);
    send(8'h01);
    send(8'h00);
    for (int j = 0; j < 16; j++) send(8'(8'hA0 + j));
    chk("t4_we", imem_we, 1);
    chk("t4_addr", imem_addr, 0);
    chk("t4_wdata", imem_wdata, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    send(8'h00);
    chk("t4_txd", tx_data, 8'hAA);
    handshake();
    chk("t4_wrcnt", wr_cnt - base, 1);

    // LEN = 2^AW + 1: addresses wrap, last bundle lands at 0; back-to-back rx
    base = wr_cnt;
    send(8'h99);
    send(8'h05);
    send(8'h00);
    for (int i = 0; i < 80; i++) send(8'(i));
    send(8'h00);
    chk("t5_txv", tx_valid, 1);
    chk("t5_txd", tx_data, 8'hAA);
    chk("t5_wrcnt", wr_cnt - base, 5);
    chk("t5_addr3", wr_addr[base+3], 3);
    chk("t5_wdata2", wr_data[base+2], 128'h2F2E2D2C2B2A29282726252423222120);
    chk("t5_addr4", wr_addr[base+4], 0);
    chk("t5_wdata4", wr_data[base+4], 128'h4F4E4D4C4B4A49484746454443424140);
    handshake();
    chk("t5_done", load_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vliw_loader.md
# vliw_loader

Boot-time program loader that sits between the UART receiver and the instruction memory of the VLIW core. It receives a framed byte stream, assembles every 16 payload bytes into one 128-bit VLIW bundle, and writes the bundles into consecutive imem addresses starting at 0. It then checks an XOR checksum and sends an ack byte back through the UART transmitter. While a load is in progress it holds the core in stall.

## Interface
Parameters:
- ADDR_W, 14, imem bundle-address width.
- START_BYTE, 8'h99, frame start marker.
- ACK_OK, 8'hAA, ack byte sent when the checksum matches.
- ACK_NG, 8'h55, ack byte sent when the checksum mismatches.

Ports:
- clk  in  1  single clock; all state is on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle. There is no backpressure.
- tx_data  out  8  ack byte to the UART transmitter.
- tx_valid  out  1  ack byte available.
- tx_ready  in  1  transmitter accepts tx_data in a cycle where tx_valid and tx_ready are both high.
- imem_we  out  1  imem write strobe.
- imem_addr  out  ADDR_W  bundle address of the write.
- imem_wdata  out  128  bundle data.
- loading  out  1  high while a frame is being processed; ORed into the core stall.
- load_done  out  1  high after the last ack has been accepted.

## Operation
- Frame format, in order:
  - START_BYTE.
  - LEN: 2 bytes, little-endian, giving the bundle count N.
  - N×16 payload bytes.
  - 1 checksum byte, equal to the XOR of all payload bytes only.
- Bundle byte order: the first byte of a bundle goes to bits [7:0], the 16th byte to bits [127:120].
- States and transitions:
  - IDLE: rx START_BYTE → LEN0. Any other byte is ignored.
  - LEN0: rx → latch LEN[7:0], go to LEN1.
  - LEN1: rx → latch LEN[15:8]. Go to DATA if LEN≠0, otherwise go to CSUM.
  - DATA: each rx byte shifts into the bundle register, the XOR accumulator is updated, and the byte counter increments (4-bit). When the 16th byte arrives, the next cycle issues an imem write at the current address. The address then increments modulo 2^ADDR_W. When the bundle counter reaches LEN → CSUM.
  - CSUM: rx → compare the received byte with the accumulator, select ACK_OK or ACK_NG, go to ACK.
  - ACK: tx_valid=1 and tx_data is held stable until tx_ready. On acceptance → DONE.
  - DONE: load_done=1. An rx START_BYTE clears load_done, resets the address, counters and accumulator, and goes to LEN0 (reload). Any other byte is ignored.
- On entry to LEN0, the following are cleared: address, byte counter, bundle counter, XOR accumulator.
- LEN greater than 2^ADDR_W wraps the addresses; earlier bundles are overwritten. This is not an error.
- rx bytes arriving in ACK are dropped.
- loading=1 in LEN0, LEN1, DATA, CSUM and ACK; it is 0 in IDLE and DONE.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - State goes to IDLE.
  - All outputs are 0: imem_we, imem_addr, imem_wdata, tx_valid, tx_data, loading, load_done.
  - All counters and the accumulator are 0.
  - A partial bundle is discarded and no imem write occurs.
- imem_we:
  - Asserted for exactly one cycle, in the cycle after the rx_valid carrying byte 16 of a bundle.
  - imem_addr and imem_wdata are valid in that same cycle and hold their values until the next write.
- Bundle throughput: at most one write per 16 rx strobes. Back-to-back rx_valid every cycle is supported.
- If byte 1 of the next bundle arrives in the same cycle as a write, it is still captured correctly, because the shift register is double-buffered into imem_wdata.
- Transition timing:
  - loading rises in the cycle after START_BYTE is accepted.
  - loading falls in the cycle after the ack handshake.
  - load_done rises in that same cycle.
- tx_valid rises in the cycle after the checksum byte. It stays high with stable data until the tx_valid∧tx_ready cycle, and is 0 in the following cycle.
- LEN=0: after the checksum byte, expected checksum 0x00, so 0x00 → ACK_OK. No imem writes.

## Test plan
- Reset, then 0x99, 0x02, 0x00, then 32 bytes 0x00..0x1F, then checksum 0x00 → two imem_we pulses:
  - addr 0, wdata 0x0F0E…0100.
  - addr 1, wdata 0x1F1E…1110.
  - Then tx 0xAA; loading falls and load_done=1.
- Same frame with checksum 0x01 → the same two writes, then tx 0x55.
- Noise bytes 0x00, 0x55, 0xAA before 0x99 are ignored. LEN=0 with checksum 0x00 → no writes, tx 0xAA.
- tx_ready held low for 10 cycles in ACK → tx_valid stays 1 and tx_data stays 0xAA for all 10 cycles; there is one handshake, then DONE. A 0x99 in DONE starts a reload at addr 0.
- rst asserted after 8 payload bytes of bundle 0 → all outputs 0 immediately. A fresh frame with LEN=1 then writes addr 0 with the new data only.
- LEN=0x4001 with ADDR_W=14 → the last bundle is written at addr 0. Rx strobes every cycle cause no lost bytes.
